fetch_unit: RTL

- Instruction-fetch (F) stage of the 5-stage pipelined RISC-V core; the consuming end of the hazard unit's Stall_F / Stall_D / Flush_D controls and of the E-stage redirect.
- Owns PC_F, drives the synchronous-read instruction BRAM, and produces the IF/ID outputs (Instr_D, PC_D, PCPlus4_D, Valid_D).
- Absorbs the BRAM's one-cycle read latency. The hazard unit only needs to raise Flush_D for one cycle per taken branch or jump; this block kills the wrong-path word already in flight in the BRAM.

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_unit_pc_next_mux.sv | 52 +++++
 rtl/fetch_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared core definitions for the fetch stage. Holds the datapath
//            width, the PC-source select encodings and the bubble instruction.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package fetch_unit_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Next-PC source selected by the E stage. Encoding 2'b11 is reserved
    // and is treated like PCSRC_TARGET.
    typedef enum logic [1:0] {
        PCSRC_PLUS4  = 2'b00,
        PCSRC_TARGET = 2'b01,
        PCSRC_JALR   = 2'b10
    } pc_src_t;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_pc_next_mux.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_mux
// Purpose  : Combinational next-PC selection for the fetch stage.
//            Priority: E-stage redirect > Stall_F hold > sequential PC+4.
//            Redirect targets are word-aligned by clearing bits [1:0].
// Ports    : i_pc_f         current fetch PC
//            i_stall_f      hold the fetch PC
//            i_pc_src_e     next-PC source select from the E stage
//            i_pc_target_e  branch / jal target
//            i_alu_result_e jalr target
//            o_pc_next      value PC_F takes on the next rising edge
// Revision : 1.0  initial release
// ============================================================================
module pc_next_mux
    import fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0] i_pc_f,
    input  logic            i_stall_f,
    input  logic [1:0]      i_pc_src_e,
    input  logic [XLEN-1:0] i_pc_target_e,
    input  logic [XLEN-1:0] i_alu_result_e,
    output logic [XLEN-1:0] o_pc_next
);

    localparam logic [XLEN-1:0] c_ALIGN_MASK = ~(XLEN'(3));
    localparam logic [XLEN-1:0] c_PC_STEP    = XLEN'(4);

    logic [XLEN-1:0] w_target;

    // Only jalr picks the ALU result; the reserved encoding falls back to
    // the branch/jal target.
    always_comb begin
        w_target = i_pc_target_e;
        if (i_pc_src_e == PCSRC_JALR) begin
            w_target = i_alu_result_e;
        end
    end

    // A redirect must win over Stall_F, otherwise a taken branch that
    // coincides with a load-use stall would be lost.
    always_comb begin
        o_pc_next = i_pc_f + c_PC_STEP;
        if (i_pc_src_e != PCSRC_PLUS4) begin
            o_pc_next = w_target & c_ALIGN_MASK;
        end else if (i_stall_f) begin
            o_pc_next = i_pc_f;
        end
    end

endmodule : pc_next_mux
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage. Owns PC_F, drives a synchronous-read
//            instruction BRAM and produces the IF/ID stage outputs. The BRAM
//            read latency is absorbed by treating the BRAM output register as
//            the D-stage instruction register; a kill flag replaces the word
//            with a NOP when the slot is a bubble.
// Ports    : clk          core clock, rising edge
//            reset_n      asynchronous active-low reset
//            Stall_F      hold PC_F
//            Stall_D      hold the IF/ID outputs
//            Flush_D      bubble the D stage
//            PC_Src_E     next-PC source (00 +4, 01 target, 10 jalr, 11 = 01)
//            PCTarget_E   branch / jal target
//            ALUResult_E  jalr target
//            imem_addr    BRAM word address
//            imem_en      BRAM read enable
//            imem_rdata   BRAM read data (one cycle after address)
//            Instr_D      D-stage instruction
//            PC_D         D-stage PC
//            PCPlus4_D    D-stage PC + 4
//            Valid_D      D-stage slot holds a real instruction
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              IMEM_AW   = 12,
    parameter logic [XLEN-1:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               Stall_F,
    input  logic               Stall_D,
    input  logic               Flush_D,
    input  logic [1:0]         PC_Src_E,
    input  logic [XLEN-1:0]    PCTarget_E,
    input  logic [XLEN-1:0]    ALUResult_E,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               imem_en,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic [XLEN-1:0]    Instr_D,
    output logic [XLEN-1:0]    PC_D,
    output logic [XLEN-1:0]    PCPlus4_D,
    output logic               Valid_D
);

    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    logic [XLEN-1:0] r_pc_f;
    logic [XLEN-1:0] r_pc_d;
    logic [XLEN-1:0] r_pcplus4_d;
    logic            r_kill_d;

    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_pcplus4_f;

    assign w_pcplus4_f = r_pc_f + c_PC_STEP;

    pc_next_mux u_pc_next_mux (
        .i_pc_f         (r_pc_f),
        .i_stall_f      (Stall_F),
        .i_pc_src_e     (PC_Src_E),
        .i_pc_target_e  (PCTarget_E),
        .i_alu_result_e (ALUResult_E),
        .o_pc_next      (w_pc_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc_f <= RESET_PC;
        end else begin
            r_pc_f <= w_pc_next;
        end
    end

    // IF/ID registers. The instruction word itself lives in the BRAM output
    // register, so only the PC pair and the kill flag are held here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc_d      <= '0;
            r_pcplus4_d <= '0;
            r_kill_d    <= 1'b1;
        end else if (Flush_D) begin
            r_pc_d      <= '0;
            r_pcplus4_d <= '0;
            r_kill_d    <= 1'b1;
        end else if (!Stall_D) begin
            r_pc_d      <= r_pc_f;
            r_pcplus4_d <= w_pcplus4_f;
            r_kill_d    <= 1'b0;
        end
    end

    // Word address wraps naturally modulo the memory depth.
    assign imem_addr = r_pc_f[IMEM_AW+1:2];

    // Disabling the BRAM during a D stall freezes its output, which is how
    // Instr_D is held. A flush re-enables it so the redirected fetch proceeds;
    // the word read in that cycle is masked by the kill flag.
    assign imem_en = ~Stall_D | Flush_D;

    assign Instr_D   = r_kill_d ? NOP_INSTR : imem_rdata;
    assign Valid_D   = ~r_kill_d;
    assign PC_D      = r_pc_d;
    assign PCPlus4_D = r_pcplus4_d;

endmodule : fetch_unit
`default_nettype wire
